// File: rtl/osborne_video_gen.sv
// Osborne-style text-mode video generator: raster counters, a two-stage character fetch
// pipeline (code/attribute, then glyph row) and an 8-bit pixel shifter with dim/reverse/underline.
module osborne_video_gen #(
  parameter int          COLS       = 52,
  parameter int          ROWS       = 24,
  parameter int          CHAR_H     = 10,
  parameter int          H_TOTAL    = 512,
  parameter int          VT_NTSC    = 262,
  parameter int          VT_PAL     = 312,
  parameter int          HS_START   = 437,
  parameter int          HS_END     = 473,
  parameter logic [15:0] VRAM_BASE  = 16'hF000,
  parameter int          ROW_STRIDE = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        pal,
  input  logic [4:0]  scroll,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_data,
  input  logic [2:0]  attr_data,
  output logic [10:0] char_addr,
  input  logic [7:0]  char_data,
  output logic        HBlank,
  output logic        HSync,
  output logic        VBlank,
  output logic        VSync,
  output logic [7:0]  video
);

  localparam int ACT_W     = COLS * 8;
  localparam int ACT_H     = ROWS * CHAR_H;
  localparam int VT_MAX    = (VT_PAL > VT_NTSC) ? VT_PAL : VT_NTSC;
  localparam int XW        = $clog2(H_TOTAL);
  localparam int YW        = $clog2(VT_MAX);
  localparam int STRIDE_SH = $clog2(ROW_STRIDE);

  // Stage 0: raster position and frame-latched mode
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] row_q, row_d;
  logic [3:0]    line_q, line_d;
  logic          pal_q, pal_d;
  logic [4:0]    scroll_q, scroll_d;
  logic [YW-1:0] y_last;
  logic          x_wrap, y_wrap;

  assign y_last = pal_q ? YW'(VT_PAL - 1) : YW'(VT_NTSC - 1);
  assign x_wrap = (x_q == XW'(H_TOTAL - 1));
  assign y_wrap = (y_q == y_last);

  // Row/line advance as a carry chain so no divider is needed for y/CHAR_H
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    row_d    = row_q;
    line_d   = line_q;
    pal_d    = pal_q;
    scroll_d = scroll_q;
    if (x_wrap) begin
      x_d = '0;
      if (y_wrap) begin
        y_d      = '0;
        row_d    = '0;
        line_d   = '0;
        pal_d    = pal;
        scroll_d = scroll;
      end else begin
        y_d = y_q + YW'(1);
        if (line_q == 4'(CHAR_H - 1)) begin
          line_d = '0;
          row_d  = row_q + YW'(1);
        end else begin
          line_d = line_q + 4'd1;
        end
      end
    end else begin
      x_d = x_q + XW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      row_q    <= '0;
      line_q   <= '0;
      pal_q    <= 1'b0;
      scroll_q <= '0;
    end else if (ce_pix) begin
      x_q      <= x_d;
      y_q      <= y_d;
      row_q    <= row_d;
      line_q   <= line_d;
      pal_q    <= pal_d;
      scroll_q <= scroll_d;
    end
  end

  // Undelayed timing decodes for the current stage-0 position
  logic hb_raw, hs_raw, vb_raw, vs_raw, active0;

  assign hb_raw  = (32'(x_q) >= ACT_W);
  assign hs_raw  = (32'(x_q) >= HS_START) && (32'(x_q) < HS_END);
  assign vb_raw  = (32'(y_q) >= ACT_H);
  assign vs_raw  = (32'(y_q) >= ACT_H + 5) && (32'(y_q) < ACT_H + 8);
  assign active0 = !hb_raw && !vb_raw;

  // Character-code address; the text row wraps modulo 32 after scrolling
  logic [4:0]  row_sum;
  logic [15:0] addr_calc;
  logic [15:0] addr_hold_q;

  assign row_sum   = 5'(row_q) + scroll_q;
  assign addr_calc = VRAM_BASE + (16'(row_sum) << STRIDE_SH) + 16'(x_q >> 3);
  assign vram_addr = active0 ? addr_calc : addr_hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hold_q <= VRAM_BASE;
    end else if (ce_pix) begin
      addr_hold_q <= vram_addr;
    end
  end

  // Stage 1: capture code and attribute returned for the stage-0 address
  logic [6:0] code_q;
  logic [2:0] attr1_q;
  logic [3:0] line1_q;
  logic [2:0] phase1_q;
  logic       vld1_q;
  logic       hb1_q, hs1_q, vb1_q, vs1_q;
  logic       unused_code_msb;

  assign unused_code_msb = vram_data[7];
  assign char_addr       = {line1_q, code_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q   <= '0;
      attr1_q  <= '0;
      line1_q  <= '0;
      phase1_q <= '0;
      vld1_q   <= 1'b0;
      hb1_q    <= 1'b0;
      hs1_q    <= 1'b0;
      vb1_q    <= 1'b0;
      vs1_q    <= 1'b0;
    end else if (ce_pix) begin
      code_q   <= vram_data[6:0];
      attr1_q  <= attr_data;
      line1_q  <= line_q;
      phase1_q <= x_q[2:0];
      vld1_q   <= 1'b1;
      hb1_q    <= hb_raw;
      hs1_q    <= hs_raw;
      vb1_q    <= vb_raw;
      vs1_q    <= vs_raw;
    end
  end

  // Stage 2: glyph shifter, loaded when stage 1 holds the first pixel of a cell
  logic [7:0] shift_q, shift_d;
  logic [2:0] attr2_q;
  logic [3:0] line2_q;
  logic       cell_load;
  logic       hb2_q, hs2_q, vb2_q, vs2_q;

  assign cell_load = (phase1_q == 3'd0);

  always_comb begin
    shift_d = {shift_q[6:0], 1'b0};
    if (cell_load) begin
      // Right after reset stage 1 holds no fetched code yet, so show nothing
      shift_d = vld1_q ? char_data : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      attr2_q <= '0;
      line2_q <= '0;
      hb2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vb2_q   <= 1'b0;
      vs2_q   <= 1'b0;
    end else if (ce_pix) begin
      shift_q <= shift_d;
      if (cell_load) begin
        attr2_q <= attr1_q;
        line2_q <= line1_q;
      end
      hb2_q <= hb1_q;
      hs2_q <= hs1_q;
      vb2_q <= vb1_q;
      vs2_q <= vs1_q;
    end
  end

  assign HBlank = hb2_q;
  assign HSync  = hs2_q;
  assign VBlank = vb2_q;
  assign VSync  = vs2_q;

  logic underline_on, pixel_on;

  assign underline_on = attr2_q[2] && (line2_q == 4'(CHAR_H - 1));
  assign pixel_on     = (shift_q[7] | underline_on) ^ attr2_q[1];

  always_comb begin
    video = 8'd0;
    if (!hb2_q && !vb2_q && pixel_on) begin
      video = attr2_q[0] ? 8'd128 : 8'd255;
    end
  end

endmodule

// File: tb/tb_osborne_video_gen.sv
// Directed bench for osborne_video_gen on a reduced raster (96 px x 40/50 lines) so that
// several whole frames fit in a short run; expected values are computed from the raster geometry.
module tb_osborne_video_gen;

  localparam int COLS     = 4;
  localparam int ROWS     = 3;
  localparam int CHAR_H   = 10;
  localparam int H_TOTAL  = 96;
  localparam int VT_NTSC  = 40;
  localparam int VT_PAL   = 50;
  localparam int HS_START = 50;
  localparam int HS_END   = 60;
  localparam int ACT_W    = COLS * 8;
  localparam int ACT_H    = ROWS * CHAR_H;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic        pal;
  logic [4:0]  scroll;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data;
  logic [2:0]  attr_data;
  logic [10:0] char_addr;
  logic [7:0]  char_data;
  logic        HBlank, HSync, VBlank, VSync;
  logic [7:0]  video;

  logic [7:0]  code_cfg;
  logic [7:0]  glyph_cfg;
  logic [2:0]  attr_cfg;

  int cyc;
  int n_assert;
  int n_fail;

  always #5 clk = ~clk;

  // Memory models: read data is valid by the clk edge following the address
  assign vram_data = code_cfg;
  assign attr_data = attr_cfg;
  assign char_data = (char_addr[6:0] == code_cfg[6:0]) ? glyph_cfg : 8'h00;

  osborne_video_gen #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .H_TOTAL(H_TOTAL),
    .VT_NTSC(VT_NTSC), .VT_PAL(VT_PAL), .HS_START(HS_START), .HS_END(HS_END),
    .VRAM_BASE(16'hF000), .ROW_STRIDE(128)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .pal(pal), .scroll(scroll),
    .vram_addr(vram_addr), .vram_data(vram_data), .attr_data(attr_data),
    .char_addr(char_addr), .char_data(char_data),
    .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync), .video(video)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic goto_cyc(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return HBlank;
      1:       return HSync;
      2:       return VBlank;
      default: return VSync;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic lvl, input int bound,
                          output int at);
    int k = 0;
    while (sig(sel) !== lvl && k < bound) begin
      step(1);
      k++;
    end
    if (sig(sel) !== lvl) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s timeout observed=%0b expected=%0b", tag, sig(sel), lvl);
    end
    at = cyc;
  endtask

  initial begin
    int at;
    int p, x;
    logic [31:0] exp_vid, exp_va;
    cyc = 0;
    n_assert = 0;
    n_fail = 0;
    reset = 1'b1;
    ce_pix = 1'b1;
    pal = 1'b0;
    scroll = 5'd0;
    code_cfg = 8'h41;
    glyph_cfg = 8'h81;
    attr_cfg = 3'd0;
    step(3);

    check("rst_hblank", HBlank, 0);
    check("rst_hsync", HSync, 0);
    check("rst_vblank", VBlank, 0);
    check("rst_vsync", VSync, 0);
    check("rst_video", video, 0);
    check("rst_vram_addr", vram_addr, 16'hF000);
    check("rst_char_addr", char_addr, 0);

    // Release at a negedge: x=0 now, so cyc equals x during the first line
    reset = 1'b0;
    cyc = 0;
    for (int j = 0; j < H_TOTAL + 2; j++) begin
      if (j > 0) step(1);
      p = j - 2;
      x = j % H_TOTAL;
      exp_vid = (j >= 2 && p < ACT_W && (p % 8 == 0 || p % 8 == 7)) ? 255 : 0;
      exp_va  = (x < ACT_W) ? 32'(16'hF000 + x / 8) : 32'h0000_F003;
      check("line0_video", video, exp_vid);
      check("line0_hblank", HBlank, (j >= 2 && p >= ACT_W) ? 1 : 0);
      check("line0_hsync", HSync, (j >= 2 && p >= HS_START && p < HS_END) ? 1 : 0);
      check("line0_vram_addr", vram_addr, exp_va);
      if (j == 5) check("line0_char_addr", char_addr, 11'h041);
      if (j == 50) check("line0_vblank", VBlank, 0);
    end

    wait_for("vblank_rise", 2, 1'b1, 5000, at);
    check("vblank_rise_cyc", at, ACT_H * H_TOTAL + 2);
    wait_for("vsync_rise", 3, 1'b1, 5000, at);
    check("vsync_rise_cyc", at, (ACT_H + 5) * H_TOTAL + 2);
    wait_for("vsync_fall", 3, 1'b0, 5000, at);
    check("vsync_fall_cyc", at, (ACT_H + 8) * H_TOTAL + 2);

    // PAL requested late in frame 0: frame 0 stays NTSC, frame 1 is PAL
    goto_cyc(3700);
    pal = 1'b1;
    wait_for("ntsc_frame", 3, 1'b1, 10000, at);
    check("ntsc_frame_vsync", at, VT_NTSC * H_TOTAL + (ACT_H + 5) * H_TOTAL + 2);

    goto_cyc(7300);
    scroll = 5'd3;
    goto_cyc(8640);
    check("scroll3_row0", vram_addr, 16'hF180);
    goto_cyc(8640 + 10 * H_TOTAL);
    scroll = 5'd30;
    check("scroll_midframe_hold", vram_addr, 16'hF200);
    goto_cyc(8640 + 20 * H_TOTAL + 8);
    check("scroll3_row2", vram_addr, 16'hF281);
    wait_for("pal_frame", 3, 1'b1, 10000, at);
    check("pal_frame_vsync", at, 8640 + (ACT_H + 5) * H_TOTAL + 2);

    goto_cyc(13440);
    check("scroll30_row0", vram_addr, 16'hFF00);
    goto_cyc(13440 + 20 * H_TOTAL);
    check("scroll30_row2_wrap", vram_addr, 16'hF000);

    step(1);
    attr_cfg = 3'd3;
    glyph_cfg = 8'h00;
    goto_cyc(13440 + 25 * H_TOTAL + 2);
    check("dimrev_p0", video, 128);
    goto_cyc(13440 + 25 * H_TOTAL + 10);
    check("dimrev_p8", video, 128);
    goto_cyc(13440 + 25 * H_TOTAL + 33);
    check("dimrev_p31", video, 128);
    step(1);
    check("dimrev_hblank", video, 0);

    goto_cyc(13440 + 26 * H_TOTAL);
    attr_cfg = 3'd7;
    goto_cyc(13440 + 28 * H_TOTAL + 5);
    check("underline_line8", video, 128);
    goto_cyc(13440 + 29 * H_TOTAL + 5);
    check("underline_line9_p3", video, 0);
    goto_cyc(13440 + 29 * H_TOTAL + 20);
    check("underline_line9_p18", video, 0);

    // Reset in the middle of an active line of the next frame
    goto_cyc(18240 + 5 * H_TOTAL + 10);
    check("pre_reset_video", video, 128);
    #2 reset = 1'b1;
    #1;
    check("midrst_video", video, 0);
    check("midrst_hblank", HBlank, 0);
    check("midrst_hsync", HSync, 0);
    check("midrst_vblank", VBlank, 0);
    check("midrst_vsync", VSync, 0);
    check("midrst_vram_addr", vram_addr, 16'hF000);
    check("midrst_char_addr", char_addr, 0);
    step(3);
    reset = 1'b0;
    cyc = 0;
    check("rel_vram_addr", vram_addr, 16'hF000);
    step(1);
    check("rel_video_j1", video, 0);
    step(1);
    check("rel_video_j2", video, 128);
    goto_cyc(10);
    check("rel_vram_addr_x10", vram_addr, 16'hF001);

    ce_pix = 1'b0;
    step(5);
    check("stall_vram_addr", vram_addr, 16'hF001);
    check("stall_video", video, 128);
    check("stall_char_addr", char_addr, 11'h041);
    check("stall_hblank", HBlank, 0);
    ce_pix = 1'b1;
    wait_for("stall_resume", 0, 1'b1, 200, at);
    check("stall_hblank_rise", at, 15 + (ACT_W + 2 - 10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/osborne_video_gen.md
OSBORNE_VIDEO_GEN -- requirements
Module: osborne_video_gen

Interface
REQ-001 Parameter COLS, default 52: character columns per text row; active width is COLS*8 pixels.
REQ-002 Parameter ROWS, default 24: text rows per frame.
REQ-003 Parameter CHAR_H, default 10, range 1..16: scanlines per character cell.
REQ-004 Parameter H_TOTAL, default 512: pixels per line, at least COLS*8+64.
REQ-005 Parameter VT_NTSC, default 262; parameter VT_PAL, default 312: lines per frame in each mode.
REQ-006 Parameter HS_START, default 437; parameter HS_END, default 473: HSync pixel window [HS_START, HS_END).
REQ-007 Parameter VRAM_BASE, default 16'hF000; parameter ROW_STRIDE, default 128 (power of two, at least COLS): video RAM layout.
REQ-008 Reset and clock are fixed: one clock; reset is asynchronous and active-high.
REQ-009 clk  in  1  system clock; all state changes on its rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 ce_pix  in  1  pixel enable; pipeline and counters advance only on edges where ce_pix=1.
REQ-012 pal  in  1  selects VT_PAL (1) or VT_NTSC (0).
REQ-013 scroll  in  5  text-row scroll offset.
REQ-014 vram_addr  out  16  video RAM character-code address.
REQ-015 vram_data  in  8  character code; bits 6:0 select the glyph.
REQ-016 attr_data  in  3  attribute for the same address: bit0 dim, bit1 reverse, bit2 underline.
REQ-017 char_addr  out  11  glyph ROM address: {line[3:0], code[6:0]}.
REQ-018 char_data  in  8  glyph row; bit 7 is the leftmost pixel.
REQ-019 HBlank, HSync, VBlank, VSync  out  1 each  timing outputs, registered.
REQ-020 video  out  8  luminance.

Function
REQ-021 Counter x SHALL count 0..H_TOTAL-1, then wrap; on wrap, y SHALL count 0..VT-1, then wrap, where VT is the latched mode.
REQ-022 pal and scroll SHALL be latched only when x and y wrap together (frame start); mid-frame changes have no effect until then.
REQ-023 Active area is x<COLS*8 and y<ROWS*CHAR_H.
REQ-024 Text row (y div CHAR_H) and line (y mod CHAR_H) SHALL come from incrementing sub-counters, not dividers; both clear at frame start.
REQ-025 vram_addr SHALL be VRAM_BASE + ((row+scroll_latched) mod 32)*ROW_STRIDE + (x div 8), formed from stage-0 counters; outside the active area it holds its last value.
REQ-026 External memories return data on the clk edge after the address is presented; the block SHALL sample vram_data/attr_data on the next ce_pix edge (stage 1) and char_data on the following ce_pix edge (stage 2).
REQ-027 char_addr SHALL be {line as seen by stage 1, registered code[6:0]}.
REQ-028 At each cell boundary, stage 2 SHALL load char_data into an 8-bit shift register with the cell's attribute, then shift left one bit per ce_pix.
REQ-029 Pixel value SHALL be: the shift-register MSB; OR 1 when underline is set and line=CHAR_H-1; then XOR reverse.
REQ-030 video SHALL be 255 for a lit normal pixel, 128 for a lit dim pixel, 0 otherwise, and forced to 0 while HBlank or VBlank.
REQ-031 HBlank, HSync, VBlank and VSync SHALL be delayed by 2 ce_pix so they align with video (total pipeline latency 2 pixels).
REQ-032 Before the delay: HBlank = x≥COLS*8; HSync = x in [HS_START, HS_END); VBlank = y≥ROWS*CHAR_H; VSync = y in [ROWS*CHAR_H+5, ROWS*CHAR_H+8).
REQ-033 With ce_pix=0, all registers SHALL hold.

Reset
REQ-034 Reset SHALL force all of the following, held while reset=1: x, y, row, line = 0; the pipeline and shift register cleared; vram_addr = VRAM_BASE; char_addr = 0; HBlank, HSync, VBlank, VSync and video = 0; pal/scroll latches = 0 (NTSC, no scroll).
REQ-035 Reset asserted mid-frame SHALL take effect immediately; the first frame after release starts at x=0, y=0.

Verification
REQ-036 Defaults, pal=0, ce_pix=1: HSync rises 439 clocks after x=0, 36 wide; one frame = 262*512 clocks.
REQ-037 pal toggled to 1 mid-frame: the current frame remains 262 lines; the next frame is 312 lines.
REQ-038 All codes 0x41 with glyph row 0x81, no attributes: video is 255, 0×6, 255 per cell; the first lit pixel lands 2 pixels after x=0.
REQ-039 attr=dim+reverse on glyph 0x00: video = 128 for the cell; with underline on line 9, that line = 0.
REQ-040 scroll=3 latched: the first text row reads vram_addr 0xF180; row 29 wraps to 0xF000.
REQ-041 Reset pulsed during active video: all outputs are 0 within the same clock; after release, vram_addr=0xF000 and x restarts at 0.
